// File: rtl/mem_responder_pkg.sv
// Shared constants and address decode for the CPU memory-bus responder.
package mem_responder_pkg;

  localparam int         RAM_ADDR_W_DEF = 17;
  localparam logic [1:0] IO_PAGE        = 2'b11;
  localparam logic [1:0] UNMAP_PAGE     = 2'b10;
  localparam logic [2:0] IO_UART        = 3'h0;
  localparam logic [2:0] IO_CLK         = 3'h4;
  localparam logic [2:0] IO_SNAP0       = 3'h5;
  localparam logic [2:0] IO_SNAP1       = 3'h6;
  localparam logic [2:0] IO_SNAP2       = 3'h7;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_NONE,
    RGN_IO
  } region_e;

  // Pages 00/01 are RAM, 10 is a hole, 11 is the I/O page.
  function automatic region_e decode_region(input logic [1:0] page);
    case (page)
      IO_PAGE:    return RGN_IO;
      UNMAP_PAGE: return RGN_NONE;
      default:    return RGN_RAM;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_tx_fifo.sv
// Circular TX byte queue; head is presented combinationally, zero when empty.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int W     = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [PTR_W:0]   cnt_o,
  output logic             valid_o,
  output logic [W-1:0]     head_o
);

  logic [W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_pop;

  assign valid_o = (cnt_q != '0);
  assign do_pop  = pop_i & valid_o;
  assign head_o  = valid_o ? mem_q[rd_q] : '0;
  assign cnt_o   = cnt_q;

  // Push and pop together leave the occupancy unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, do_pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_in) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (do_pop) rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Bus target for the CPU: byte RAM, UART RX/TX, cycle counter and stop flag.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_ADDR_W = RAM_ADDR_W_DEF,
  parameter int TX_DEPTH   = 8,
  parameter int TX_PTR_W   = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_done
);

  localparam int CNT_W = TX_PTR_W + 1;

  logic [CNT_W-1:0]      tx_cnt;
  region_e               rgn;
  logic [2:0]            io_off;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  rd_acc, wr_acc, ram_we, ram_re, io_rd, io_wr;
  logic                  stop_wr, tx_push;
  byte_t                 tx_push_data;
  logic                  unused_a;

  byte_t       ram [2**RAM_ADDR_W];
  byte_t       ram_rd_q;
  byte_t       io_d, io_q;
  logic        sel_ram_d, sel_ram_q;
  logic [31:0] cnt_d, cnt_q;
  logic [23:0] snap_d, snap_q;
  logic        prog_done_d, prog_done_q;

  // Keep one slot spare so a write accepted this cycle always fits.
  assign rdy_out  = (tx_cnt <= CNT_W'(TX_DEPTH - 2));

  assign rgn      = decode_region(mem_a[17:16]);
  assign io_off   = mem_a[2:0];
  assign ram_idx  = mem_a[RAM_ADDR_W-1:0];
  assign unused_a = ^mem_a;

  assign rd_acc   = rdy_out & ~mem_wr;
  assign wr_acc   = rdy_out &  mem_wr;
  assign ram_we   = wr_acc & (rgn == RGN_RAM);
  assign ram_re   = rd_acc & (rgn == RGN_RAM);
  assign io_rd    = rd_acc & (rgn == RGN_IO);
  assign io_wr    = wr_acc & (rgn == RGN_IO);

  assign rx_ready     = rst_in & io_rd & (io_off == IO_UART) & rx_valid;
  assign stop_wr      = io_wr & (io_off == IO_CLK);
  assign tx_push      = stop_wr | (io_wr & (io_off == IO_UART) & (mem_dout != 8'h00));
  assign tx_push_data = stop_wr ? 8'h00 : mem_dout;

  assign mem_din   = sel_ram_q ? ram_rd_q : io_q;
  assign prog_done = prog_done_q;

  // Read-data source select, I/O read mux and counter snapshot capture.
  always_comb begin
    io_d        = io_q;
    snap_d      = snap_q;
    sel_ram_d   = sel_ram_q;
    cnt_d       = cnt_q + 32'd1;
    prog_done_d = prog_done_q | stop_wr;
    if (rd_acc) begin
      sel_ram_d = (rgn == RGN_RAM);
      io_d      = 8'h00;
      if (io_rd) begin
        case (io_off)
          IO_UART:  io_d = rx_valid ? rx_data : 8'h00;
          IO_CLK: begin
            io_d   = cnt_q[7:0];
            snap_d = cnt_q[31:8];
          end
          IO_SNAP0: io_d = snap_q[7:0];
          IO_SNAP1: io_d = snap_q[15:8];
          IO_SNAP2: io_d = snap_q[23:16];
          default:  io_d = 8'h00;
        endcase
      end
    end
  end

  // Byte RAM with a registered read port so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= mem_dout;
    if (ram_re) ram_rd_q <= ram[ram_idx];
  end

  // Resettable responder state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      io_q        <= 8'h00;
      sel_ram_q   <= 1'b0;
      cnt_q       <= '0;
      snap_q      <= '0;
      prog_done_q <= 1'b0;
    end else begin
      io_q        <= io_d;
      sel_ram_q   <= sel_ram_d;
      cnt_q       <= cnt_d;
      snap_q      <= snap_d;
      prog_done_q <= prog_done_d;
    end
  end

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .PTR_W (TX_PTR_W),
    .W     (8)
  ) u_tx_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .push_i  (tx_push),
    .data_i  (tx_push_data),
    .pop_i   (tx_ready),
    .cnt_o   (tx_cnt),
    .valid_o (tx_valid),
    .head_o  (tx_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table vectors, directed corner sequences, random traffic.
module tb_mem_responder;

  localparam int TX_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_a = 32'h0002_0000;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = 8'h00;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        prog_done;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .mem_a     (mem_a),
    .mem_wr    (mem_wr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .rdy_out   (rdy_out),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .prog_done (prog_done)
  );

  // Reference model state: what the bus target should look like.
  logic [7:0]  ram_m [int];
  logic [7:0]  txq [$];
  logic [31:0] cnt_m;
  logic [23:0] snap_m;
  logic        prog_m;
  logic [7:0]  din_m;
  bit          din_known;
  logic        rxr_seen;
  int          n_tests = 0;
  int          n_fail = 0;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        rxv;
    logic [7:0]  rxd;
    logic        cd;
    logic [7:0]  din;
    logic        rxr;
    logic        txv;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    txq.delete();
    cnt_m     = 32'd0;
    snap_m    = 24'd0;
    prog_m    = 1'b0;
    din_m     = 8'h00;
    din_known = 1'b1;
  endtask

  task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr   = wr;
    mem_a    = a;
    mem_dout = d;
  endtask

  // One bus cycle: check combinational outputs, step the model and the clock,
  // then check registered outputs.
  task automatic cyc();
    bit         acc, pop, push;
    logic [7:0] pv;
    logic [1:0] pg;
    logic [2:0] off;
    int         idx;
    #1;
    acc = (txq.size() <= TX_DEPTH - 2);
    pg  = mem_a[17:16];
    off = mem_a[2:0];
    idx = int'(mem_a[16:0]);
    chk("rdy_out", rdy_out, acc);
    chk("rx_ready", rx_ready, acc && !mem_wr && pg == 2'b11 && off == 3'd0 && rx_valid);
    rxr_seen = rx_ready;
    pop  = (txq.size() != 0) && tx_ready;
    push = 0;
    pv   = 8'h00;
    if (acc) begin
      if (mem_wr) begin
        din_known = 0;
        if (pg < 2) ram_m[idx] = mem_dout;
        else if (pg == 3 && off == 0 && mem_dout != 0) begin push = 1; pv = mem_dout; end
        else if (pg == 3 && off == 4) begin push = 1; pv = 8'h00; prog_m = 1'b1; end
      end else begin
        din_known = 1;
        if (pg < 2) begin
          if (ram_m.exists(idx)) din_m = ram_m[idx];
          else din_known = 0;
        end else if (pg == 2) din_m = 8'h00;
        else begin
          case (off)
            3'd0: din_m = rx_valid ? rx_data : 8'h00;
            3'd4: begin din_m = cnt_m[7:0]; snap_m = cnt_m[31:8]; end
            3'd5: din_m = snap_m[7:0];
            3'd6: din_m = snap_m[15:8];
            3'd7: din_m = snap_m[23:16];
            default: din_m = 8'h00;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
    if (pop) void'(txq.pop_front());
    if (push) txq.push_back(pv);
    cnt_m = cnt_m + 32'd1;
    if (din_known) chk("mem_din", mem_din, din_m);
    chk("tx_valid", tx_valid, txq.size() != 0);
    chk("tx_data", tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
    chk("prog_done", prog_done, prog_m);
  endtask

  task automatic idle();
    bus(1'b0, 32'h0002_0000, 8'h00);
    cyc();
  endtask

  vec_t        vecs [16];
  logic [7:0]  got [$];
  int          pool [8];

  initial begin
    reset_model();
    #22;
    // Reset state
    chk("rst mem_din", mem_din, 8'h00);
    chk("rst tx_valid", tx_valid, 1'b0);
    chk("rst tx_data", tx_data, 8'h00);
    chk("rst prog_done", prog_done, 1'b0);
    chk("rst rx_ready", rx_ready, 1'b0);
    chk("rst rdy_out", rdy_out, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: {wr, addr, data, rx_valid, rx_data, check din?, din, rx_ready, tx_valid}
    vecs[0]  = '{1'b1, 32'h0000_0010, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0002_0004, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0001_FFFF, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'hFFFD_FFFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0001_0010, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0001_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h0002_0010, 8'h99, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0002_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h41, 1'b1, 8'h41, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h42, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 32'h0003_0003, 8'h00, 1'b1, 8'h43, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 32'h0003_0001, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].wr, vecs[i].a, vecs[i].d);
      rx_valid = vecs[i].rxv;
      rx_data  = vecs[i].rxd;
      cyc();
      chk($sformatf("vec%0d rx_ready", i), rxr_seen, vecs[i].rxr);
      chk($sformatf("vec%0d tx_valid", i), tx_valid, vecs[i].txv);
      if (vecs[i].cd) chk($sformatf("vec%0d mem_din", i), mem_din, vecs[i].din);
    end
    rx_valid = 1'b0;

    // TX back-pressure: seven pushes fill to the threshold, the eighth is refused.
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus(1'b1, 32'h0003_0000, 8'h31 + 8'(i));
      cyc();
    end
    chk("bp rdy_out low", rdy_out, 1'b0);
    bus(1'b1, 32'h0003_0000, 8'h38);
    cyc();
    chk("bp rdy_out still low", rdy_out, 1'b0);
    tx_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 20; i++) begin
      bus(1'b0, 32'h0002_0000, 8'h00);
      #1;
      if (!tx_valid) break;
      got.push_back(tx_data);
      cyc();
      if (i == 0) chk("bp rdy_out rises at 6", rdy_out, 1'b1);
    end
    chk("bp drained count", got.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("bp byte%0d", i), (i < got.size()) ? got[i] : 8'hXX, 8'h31 + 8'(i));
    tx_ready = 1'b0;
    bus(1'b1, 32'h0003_0000, 8'h00);
    cyc();
    chk("zero write no push", tx_valid, 1'b0);

    // Cycle counter snapshot.
    for (int i = 0; i < 300; i++) idle();
    bus(1'b0, 32'h0003_0004, 8'h00); cyc();
    got.delete();
    got.push_back(mem_din);
    for (int i = 5; i < 8; i++) begin
      bus(1'b0, 32'h0003_0000 | 32'(i), 8'h00);
      cyc();
      got.push_back(mem_din);
    end
    chk("counter snapshot", {got[3], got[2], got[1], got[0]}, cnt_m - 32'd4);

    // Program stop.
    bus(1'b1, 32'h0003_0004, 8'h99);
    cyc();
    chk("stop prog_done", prog_done, 1'b1);
    chk("stop tx_valid", tx_valid, 1'b1);
    chk("stop tx_data", tx_data, 8'h00);
    bus(1'b1, 32'h0000_0020, 8'h12); cyc();
    bus(1'b0, 32'h0000_0020, 8'h00); cyc();
    bus(1'b1, 32'h0003_0000, 8'h44); cyc();
    chk("stop sticky", prog_done, 1'b1);

    // Counter wrap.
    force dut.cnt_q = 32'hFFFF_FFFF;
    cnt_m = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    bus(1'b0, 32'h0003_0004, 8'h00); cyc();
    chk("wrap pre", mem_din, 8'hFF);
    bus(1'b0, 32'h0003_0004, 8'h00); cyc();
    chk("wrap post", mem_din, 8'h00);
    bus(1'b0, 32'h0003_0007, 8'h00); cyc();
    chk("wrap snap", mem_din, 8'h00);

    // Asynchronous reset in the middle of a drain.
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, 32'h0003_0000, 8'h61 + 8'(i));
      cyc();
    end
    bus(1'b0, 32'h0000_0010, 8'h00); cyc();
    tx_ready = 1'b1;
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst tx_valid", tx_valid, 1'b0);
    chk("arst tx_data", tx_data, 8'h00);
    chk("arst mem_din", mem_din, 8'h00);
    chk("arst prog_done", prog_done, 1'b0);
    chk("arst rdy_out", rdy_out, 1'b1);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 8; i++) begin
      pool[i] = int'($urandom_range(0, 32'h1FFFF));
      bus(1'b1, {$urandom_range(0, 16383), 1'b0, pool[i][16:0]}, 8'($urandom));
      cyc();
    end
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      int          op;
      a        = $urandom();
      op       = int'($urandom_range(0, 9));
      tx_ready = ($urandom_range(0, 9) < 4);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      case (op)
        0, 1, 2: begin a[17:0] = {1'b0, pool[$urandom_range(0, 7)][16:0]}; bus(1'b1, a, 8'($urandom)); end
        3, 4:    begin a[17:0] = {1'b0, pool[$urandom_range(0, 7)][16:0]}; bus(1'b0, a, 8'h00); end
        5:       begin a[17:16] = 2'b11; a[2:0] = 3'd0;
                   bus(1'b1, a, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom)); end
        6:       begin a[17:16] = 2'b11; bus(1'b0, a, 8'h00); end
        7:       begin a[17:16] = 2'b10; bus(1'($urandom), a, 8'($urandom)); end
        8:       begin a[17:16] = 2'b11; if (a[2:0] == 3'd4 && $urandom_range(0, 3) != 0) a[0] = 1'b1;
                   bus(1'b1, a, 8'($urandom)); end
        default: begin a[17:16] = 2'b10; bus(1'b0, a, 8'h00); end
      endcase
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
